// File: rtl/xunit_f.sv
// SHA-256 compression engine: one 64-round compression per run pulse,
// with W_t streamed in from an external message-schedule unit.
module xunit_f #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic              done,
   input  logic [DATA_W-1:0] in0,
   input  logic              init,
   input  logic [7:0]        delay0,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic [DATA_W-1:0] out3,
   output logic [DATA_W-1:0] out4,
   output logic [DATA_W-1:0] out5,
   output logic [DATA_W-1:0] out6,
   output logic [DATA_W-1:0] out7
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_FINAL = 2'd3;

   // Index 0 holds H0 / a, index 7 holds H7 / h.
   localparam logic [7:0][DATA_W-1:0] IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   localparam logic [DATA_W-1:0] K_ROM [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   logic [1:0]               state_q, state_d;
   logic [7:0]               cnt_q, cnt_d;
   logic [5:0]               t_q, t_d;
   logic [7:0][DATA_W-1:0]   wv_q, wv_d;
   logic [7:0][DATA_W-1:0]   hash_q, hash_d;
   logic [DATA_W-1:0]        k_t;
   logic [DATA_W-1:0]        t1;
   logic [DATA_W-1:0]        t2;
   logic [7:0][DATA_W-1:0]   wv_round;

   assign k_t = K_ROM[t_q];

   always_comb begin
      t1 = wv_q[7] + big_s1(wv_q[4]) + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6])) + k_t + in0;
      t2 = big_s0(wv_q[0]) + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
      wv_round    = wv_q;
      wv_round[0] = t1 + t2;
      wv_round[1] = wv_q[0];
      wv_round[2] = wv_q[1];
      wv_round[3] = wv_q[2];
      wv_round[4] = wv_q[3] + t1;
      wv_round[5] = wv_q[4];
      wv_round[6] = wv_q[5];
      wv_round[7] = wv_q[6];
   end

   // run always wins, including over the FINAL hash accumulation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      t_d     = t_q;
      wv_d    = wv_q;
      hash_d  = hash_q;
      if (run) begin
         cnt_d   = delay0;
         t_d     = 6'd0;
         state_d = S_WAIT;
         if (init) begin
            hash_d = IV;
            wv_d   = IV;
         end else begin
            wv_d   = hash_q;
         end
      end else begin
         case (state_q)
            S_WAIT, S_ROUND: begin
               if (state_q == S_WAIT && cnt_q != 8'd0) begin
                  cnt_d = cnt_q - 8'd1;
               end else begin
                  wv_d    = wv_round;
                  t_d     = t_q + 6'd1;
                  state_d = (t_q == 6'd63) ? S_FINAL : S_ROUND;
               end
            end
            S_FINAL: begin
               for (int i = 0; i < 8; i++) begin
                  hash_d[i] = hash_q[i] + wv_q[i];
               end
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         t_q     <= '0;
         wv_q    <= '0;
         hash_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_q     <= t_d;
         wv_q    <= wv_d;
         hash_q  <= hash_d;
      end
   end

   assign done = (state_q == S_IDLE);
   assign out0 = hash_q[0];
   assign out1 = hash_q[1];
   assign out2 = hash_q[2];
   assign out3 = hash_q[3];
   assign out4 = hash_q[4];
   assign out5 = hash_q[5];
   assign out6 = hash_q[6];
   assign out7 = hash_q[7];

endmodule

// File: doc/xunit_f.md
XUNIT_F -- requirements
Module: xunit_f

Interface
REQ-001 Parameter DATA_W, default 32, datapath word width; only 32 is supported.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 run  input  1  start pulse; begins one 64-round compression.
REQ-005 done  output  1  high when idle, i.e. no compression in progress.
REQ-006 in0  input  32  message-schedule word stream W_t from the upstream schedule unit.
REQ-007 init  input  1  config; sampled on run: 1 = start a new message from the IV, 0 = chain from current hash.
REQ-008 delay0  input  8  config; cycles to wait after run before W_0 is taken.
REQ-009 out0..out7  output  32 each  hash words H0..H7, registered.

Function
REQ-010 The states SHALL be IDLE, WAIT, ROUND and FINAL; done SHALL be 1 exactly in IDLE.
REQ-011 run=1 in any state SHALL restart: cnt<=delay0, t<=0, state<=WAIT; an in-progress compression is abandoned with H unchanged.
REQ-012 On run with init=1 the block SHALL load H0..H7 with the SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) and a..h with the IV.
REQ-013 On run with init=0 the block SHALL load a..h with the current H0..H7.
REQ-014 In WAIT with cnt!=0 the block SHALL decrement cnt and ignore in0.
REQ-015 In WAIT with cnt==0, and in every ROUND cycle, the block SHALL consume in0 as W_t and perform round t, then increment t; WAIT->ROUND on that cycle.
REQ-016 Round t: T1=h+S1(e)+Ch(e,f,g)+K_t+W_t, T2=S0(a)+Maj(a,b,c); h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
REQ-017 S0=ROTR2^ROTR13^ROTR22, S1=ROTR6^ROTR11^ROTR25, Ch=(e&f)^(~e&g), Maj=(a&b)^(a&c)^(b&c).
REQ-018 All additions SHALL be modulo 2^32 with carries discarded.
REQ-019 K_0..K_63 SHALL be the FIPS 180-4 SHA-256 constants held in an internal ROM indexed by the 6-bit t.
REQ-020 After round 63 the block SHALL go to FINAL, and FINAL SHALL update Hi<=Hi+var_i for i=0..7 (var_0=a...var_7=h), then go to IDLE.
REQ-021 Latency: with run at cycle 0, W_t SHALL be sampled at cycle delay0+1+t, FINAL SHALL occur at cycle delay0+65, and done SHALL read 1 from cycle delay0+66.
REQ-022 out0..out7 SHALL reflect H0..H7 at all times and SHALL change only at run with init=1, in FINAL, or at reset.
REQ-023 t SHALL be 6 bits; the wrap from 63 SHALL never be used as round 0 (the FINAL transition takes precedence).
REQ-024 run coincident with the FINAL cycle SHALL take precedence: H is not updated.
REQ-025 In IDLE, in0, init and delay0 SHALL be ignored unless run=1.

Reset
REQ-026 rst SHALL force state IDLE (done=1), cnt=0, t=0, a..h=0 and H0..H7 (out0..out7)=0, irrespective of clock.
REQ-027 rst asserted mid-compression SHALL abort it, and the next run SHALL behave as from power-up.

Verification
REQ-028 Empty message: run, init=1, delay0=0, feed the 64 W words expanded from W0=80000000, W1..W15=0 -> after done, out0..7 = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-029 "abc": init=1, delay0=5, feed the W words expanded from W0=61626380, W15=00000018, all other W=0 -> first W sampled at cycle 6, done at cycle 71, out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-030 Two-block chaining: block 1 with init=1, then block 2 with init=0 -> out equals the reference model digest of the 2-block message (e.g. the 56-byte "abcdbcdecdef..." vector, ending 19db06c1).
REQ-031 Restart: run again at round 30 with init=1 -> H unchanged until the new FINAL, and the result equals a clean run.
REQ-032 Async reset: assert rst mid-ROUND between clock edges -> done=1 and out0..7=0 immediately; a subsequent "abc" run gives the correct digest.
REQ-033 Boundary: delay0=255 -> W_0 sampled at cycle 256; the changing in0 values applied during WAIT have no effect on the digest.
